// File: rtl/elevator_car_ctrl.sv
// SCAN-style elevator car controller: serves latched floor requests, drives motor and door.
// Define DOOR_REOPEN_EN to add the door_obstruct input (reopen on obstruction while closing).
module elevator_car_ctrl #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_W       = 3,
    parameter int FLOOR_TICKS   = 16,
    parameter int DOOR_TICKS    = 32,
    parameter int CLOSE_TICKS   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef DOOR_REOPEN_EN
    input  logic                     door_obstruct,
`endif
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] clr_in_levels,
    output logic [BUTTONS_WIDTH-1:0] clr_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] clr_out_down_levels,
    output logic [FLOOR_W-1:0]       current_floor,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic                     door_open,
    output logic                     dir_up,
    output logic                     busy
);
    localparam int BW       = BUTTONS_WIDTH;
    localparam int TICK_MAX = (FLOOR_TICKS > DOOR_TICKS)
                              ? ((FLOOR_TICKS > CLOSE_TICKS) ? FLOOR_TICKS : CLOSE_TICKS)
                              : ((DOOR_TICKS > CLOSE_TICKS) ? DOOR_TICKS : CLOSE_TICKS);
    localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_MOVING       = 2'd1;
    localparam logic [1:0] S_DOOR_OPEN    = 2'd2;
    localparam logic [1:0] S_DOOR_CLOSING = 2'd3;

    localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);
    localparam logic [TW-1:0] CLOSE_LOAD = TW'(CLOSE_TICKS - 1);

    function automatic logic any_above(input logic [BW-1:0] r, input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < BW; i++)
            if (i > int'(f) && r[i]) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input logic [BW-1:0] r, input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < BW; i++)
            if (i < int'(f) && r[i]) any_below = 1'b1;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [BW-1:0]      m_in_q, m_in_d, m_up_q, m_up_d, m_dn_q, m_dn_d;
    logic [BW-1:0]      clr_in_q, clr_up_q, clr_dn_q;
    logic               motor_up_q, motor_down_q, door_open_q, busy_q;

    logic [BW-1:0]      req, oh_cur, oh_next;
    logic [FLOOR_W-1:0] next_floor;
    logic               above_cur, below_cur, above_next, below_next;
    logic [BW-1:0]      mv_in, mv_up, mv_dn;
    logic               mv_stop;

    assign req        = active_in_levels | active_out_up_levels | active_out_down_levels;
    assign next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign oh_cur     = BW'(1) << floor_q;
    assign oh_next    = BW'(1) << next_floor;
    assign above_cur  = any_above(req, floor_q);
    assign below_cur  = any_below(req, floor_q);
    assign above_next = any_above(req, next_floor);
    assign below_next = any_below(req, next_floor);

    // Opposite-direction hall call at the arrival floor is only taken when nothing lies further on.
    assign mv_in   = active_in_levels & oh_next;
    assign mv_up   = (dir_q || !below_next) ? (active_out_up_levels & oh_next) : '0;
    assign mv_dn   = (!dir_q || !above_next) ? (active_out_down_levels & oh_next) : '0;
    assign mv_stop = dir_q ? ((|(mv_in | mv_up)) || !above_next)
                           : ((|(mv_in | mv_dn)) || !below_next);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        m_in_d  = m_in_q;
        m_up_d  = m_up_q;
        m_dn_d  = m_dn_q;
        case (state_q)
            S_IDLE: begin
                if (|(req & oh_cur)) begin
                    state_d = S_DOOR_OPEN;
                    timer_d = DOOR_LOAD;
                    m_in_d  = active_in_levels & oh_cur;
                    m_up_d  = active_out_up_levels & oh_cur;
                    m_dn_d  = active_out_down_levels & oh_cur;
                end else if (above_cur && (dir_q || !below_cur)) begin
                    dir_d   = 1'b1;
                    state_d = S_MOVING;
                    timer_d = FLOOR_LOAD;
                end else if (below_cur) begin
                    dir_d   = 1'b0;
                    state_d = S_MOVING;
                    timer_d = FLOOR_LOAD;
                end
            end
            S_MOVING: begin
                if (timer_q == '0) begin
                    floor_d = next_floor;
                    timer_d = FLOOR_LOAD;
                    if (mv_stop) begin
                        m_in_d  = mv_in;
                        m_up_d  = mv_up;
                        m_dn_d  = mv_dn;
                        timer_d = DOOR_LOAD;
                        state_d = (|(mv_in | mv_up | mv_dn)) ? S_DOOR_OPEN : S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DOOR_OPEN: begin
                if (timer_q == '0) begin
                    state_d = S_DOOR_CLOSING;
                    timer_d = CLOSE_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
`ifdef DOOR_REOPEN_EN
                if (door_obstruct) begin
                    state_d = S_DOOR_OPEN;
                    timer_d = DOOR_LOAD;
                end
`endif
            end
            default: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
`ifdef DOOR_REOPEN_EN
                if (door_obstruct) begin
                    state_d = S_DOOR_OPEN;
                    timer_d = DOOR_LOAD;
                end
`endif
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            floor_q      <= '0;
            dir_q        <= 1'b1;
            timer_q      <= '0;
            m_in_q       <= '0;
            m_up_q       <= '0;
            m_dn_q       <= '0;
            clr_in_q     <= '0;
            clr_up_q     <= '0;
            clr_dn_q     <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            m_in_q       <= m_in_d;
            m_up_q       <= m_up_d;
            m_dn_q       <= m_dn_d;
            clr_in_q     <= (state_d == S_DOOR_OPEN) ? m_in_d : '0;
            clr_up_q     <= (state_d == S_DOOR_OPEN) ? m_up_d : '0;
            clr_dn_q     <= (state_d == S_DOOR_OPEN) ? m_dn_d : '0;
            motor_up_q   <= (state_d == S_MOVING) && dir_d;
            motor_down_q <= (state_d == S_MOVING) && !dir_d;
            door_open_q  <= (state_d == S_DOOR_OPEN);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign clr_in_levels       = clr_in_q;
    assign clr_out_up_levels   = clr_up_q;
    assign clr_out_down_levels = clr_dn_q;
    assign current_floor       = floor_q;
    assign motor_up            = motor_up_q;
    assign motor_down          = motor_down_q;
    assign door_open           = door_open_q;
    assign dir_up              = dir_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with short timing parameters; expectations are cycle-exact.
module tb_elevator_car_ctrl;
    logic       clk;
    logic       reset;
`ifdef DOOR_REOPEN_EN
    logic       door_obstruct;
`endif
    logic [7:0] in_lv, up_lv, dn_lv;
    logic [7:0] clr_in, clr_up, clr_dn;
    logic [2:0] current_floor;
    logic       motor_up, motor_down, door_open, dir_up, busy;

    int checks = 0;
    int errors = 0;

    elevator_car_ctrl #(
        .BUTTONS_WIDTH(8),
        .FLOOR_W(3),
        .FLOOR_TICKS(4),
        .DOOR_TICKS(6),
        .CLOSE_TICKS(3)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
`ifdef DOOR_REOPEN_EN
        .door_obstruct         (door_obstruct),
`endif
        .active_in_levels      (in_lv),
        .active_out_up_levels  (up_lv),
        .active_out_down_levels(dn_lv),
        .clr_in_levels         (clr_in),
        .clr_out_up_levels     (clr_up),
        .clr_out_down_levels   (clr_dn),
        .current_floor         (current_floor),
        .motor_up              (motor_up),
        .motor_down            (motor_down),
        .door_open             (door_open),
        .dir_up                (dir_up),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_core(input string tag, input logic [2:0] fl, input logic mu,
                               input logic md, input logic dr, input logic bz);
        chk_vec({tag, ".floor"}, {5'b0, current_floor}, {5'b0, fl});
        chk_bit({tag, ".motor_up"}, motor_up, mu);
        chk_bit({tag, ".motor_down"}, motor_down, md);
        chk_bit({tag, ".door_open"}, door_open, dr);
        chk_bit({tag, ".busy"}, busy, bz);
    endtask

    task automatic expect_clr(input string tag, input logic [7:0] ei, input logic [7:0] eu,
                              input logic [7:0] ed);
        chk_vec({tag, ".clr_in"}, clr_in, ei);
        chk_vec({tag, ".clr_up"}, clr_up, eu);
        chk_vec({tag, ".clr_dn"}, clr_dn, ed);
    endtask

    // Leaves the bench 1 time unit after the first edge following reset release (car IDLE at 0).
    task automatic reset_dut();
        reset = 1'b0;
        in_lv = '0;
        up_lv = '0;
        dn_lv = '0;
        tick(2);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
`ifdef DOOR_REOPEN_EN
        door_obstruct = 1'b0;
`endif
        reset = 1'b0;
        in_lv = '0;
        up_lv = '0;
        dn_lv = '0;
        tick(2);
        expect_core("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_clr("reset", 8'h00, 8'h00, 8'h00);
        chk_bit("reset.dir_up", dir_up, 1'b1);

        // Single in-car call to floor 3
        reset_dut();
        expect_core("t1_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_lv = 8'h08;
        tick(1);
        expect_core("t1_start", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        expect_core("t1_c4", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        expect_core("t1_f1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(4);
        expect_core("t1_f2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        expect_core("t1_c12", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        expect_core("t1_arrive", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t1_arrive", 8'h08, 8'h00, 8'h00);
        in_lv = '0;
        tick(5);
        expect_core("t1_door_last", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t1_door_last", 8'h08, 8'h00, 8'h00);
        tick(1);
        expect_core("t1_closing", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_clr("t1_closing", 8'h00, 8'h00, 8'h00);
        tick(2);
        chk_bit("t1_close_last.busy", busy, 1'b1);
        tick(1);
        expect_core("t1_idle_end", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hall-up at 2 is collected on the way to hall-down at 5
        reset_dut();
        up_lv = 8'h04;
        dn_lv = 8'h20;
        tick(1);
        expect_core("t2_start", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(8);
        expect_core("t2_stop2", 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t2_stop2", 8'h00, 8'h04, 8'h00);
        up_lv = '0;
        tick(9);
        expect_core("t2_idle2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_core("t2_leave2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(12);
        expect_core("t2_stop5", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t2_stop5", 8'h00, 8'h00, 8'h20);
        dn_lv = '0;
        tick(9);

        // Hall-down at 4 is skipped going up, served after reversing at 6
        reset_dut();
        in_lv = 8'h40;
        tick(1);
        expect_core("t3_start", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(4);
        dn_lv = 8'h10;
        tick(12);
        expect_core("t3_pass4", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_clr("t3_pass4", 8'h00, 8'h00, 8'h00);
        tick(8);
        expect_core("t3_stop6", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t3_stop6", 8'h40, 8'h00, 8'h00);
        in_lv = '0;
        tick(9);
        expect_core("t3_idle6", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_core("t3_reverse", 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_bit("t3_reverse.dir_up", dir_up, 1'b0);
        tick(8);
        expect_core("t3_stop4", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t3_stop4", 8'h00, 8'h00, 8'h10);
        dn_lv = '0;
        tick(9);
        expect_core("t3_idle4", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        // With dir_up=0 and calls on both sides, the car goes down first
        in_lv = 8'h42;
        tick(1);
        expect_core("t4_down_first", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_bit("t4_down_first.dir_up", dir_up, 1'b0);
        tick(2);
        expect_core("t4_mid_move", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a move, checked before the next edge
        #2;
        reset = 1'b0;
        #1;
        expect_core("t5_async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_clr("t5_async_rst", 8'h00, 8'h00, 8'h00);
        chk_bit("t5_async_rst.dir_up", dir_up, 1'b1);

        // Call at the current floor opens the door straight from IDLE with all three bits served
        reset_dut();
        in_lv = 8'h01;
        up_lv = 8'h01;
        dn_lv = 8'h01;
        tick(1);
        expect_core("t6_open_here", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t6_open_here", 8'h01, 8'h01, 8'h01);
        in_lv = '0;
        up_lv = '0;
        dn_lv = '0;
        tick(5);
        chk_bit("t6_door_last.door_open", door_open, 1'b1);
        tick(1);
        expect_core("t6_closing", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_clr("t6_closing", 8'h00, 8'h00, 8'h00);
`ifdef DOOR_REOPEN_EN
        door_obstruct = 1'b1;
        tick(1);
        door_obstruct = 1'b0;
        expect_core("t7_reopen", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t7_reopen", 8'h01, 8'h01, 8'h01);
        tick(5);
        chk_bit("t7_reopen_last.door_open", door_open, 1'b1);
        tick(1);
        chk_bit("t7_reclose.door_open", door_open, 1'b0);
        tick(3);
        expect_core("t7_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        // New call at this floor during closing: closing completes, then IDLE reopens
        in_lv = 8'h01;
        tick(2);
        expect_core("t7_close_last", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        expect_core("t7_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_core("t7_reopen", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_clr("t7_reopen", 8'h01, 8'h00, 8'h00);
        in_lv = '0;
`endif
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Interlocks that hold on every cycle
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            assert (!(motor_up && motor_down) && !(door_open && (motor_up || motor_down))) else begin
                errors++;
                $error("FAIL interlock: observed mu=%b md=%b door=%b expected exclusive",
                       motor_up, motor_down, door_open);
            end
        end
    end
endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Car controller that consumes the latched request vectors from the button-latch block and serves them. Runs a direction-preserving collective (SCAN) algorithm, drives the motor and door, and tracks the current floor. Issues per-floor clear strobes back to the request latch when a floor is served. Sits between the button latch and the car/door actuators.

Parameters:
BUTTONS_WIDTH, 8, number of floors (one request bit per floor)
FLOOR_W, 3, width of current_floor; must satisfy 2**FLOOR_W >= BUTTONS_WIDTH
FLOOR_TICKS, 16, clock cycles to travel one floor (>=1)
DOOR_TICKS, 32, clock cycles door stays open (>=1)
CLOSE_TICKS, 8, clock cycles for the door-closing phase (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
active_in_levels  input  BUTTONS_WIDTH  latched in-car requests, bit = floor
active_out_up_levels  input  BUTTONS_WIDTH  latched hall-up requests
active_out_down_levels  input  BUTTONS_WIDTH  latched hall-down requests
clr_in_levels  output  BUTTONS_WIDTH  clear strobe for in-car requests
clr_out_up_levels  output  BUTTONS_WIDTH  clear strobe for hall-up requests
clr_out_down_levels  output  BUTTONS_WIDTH  clear strobe for hall-down requests
current_floor  output  FLOOR_W  floor index of car
motor_up  output  1  car moving up
motor_down  output  1  car moving down
door_open  output  1  door open command
dir_up  output  1  current/last travel direction (1 = up)
busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low. State=IDLE, current_floor=0, dir_up=1, all timers 0, all clr_* 0, motor_up/motor_down/door_open/busy 0. Reset mid-travel abandons the move; floor returns to 0 (car treated as homed).
- Definitions: req = in|up|down; above(f) = any req bit > f; below(f) = any req bit < f; here(f) = req[f].
- States: IDLE, MOVING, DOOR_OPEN, DOOR_CLOSING. All outputs registered.
- IDLE (min 1 cycle, decision registered):
  - here(f): go DOOR_OPEN; serve mask = in[f], up[f], down[f] (all three); dir_up unchanged.
  - else above(f) and (dir_up or !below(f)): dir_up=1, go MOVING.
  - else below(f): dir_up=0, go MOVING.
  - else stay IDLE.
- MOVING: motor_up=dir_up, motor_down=!dir_up. Tick counter loads FLOOR_TICKS-1 on entry, decrements each cycle. At 0: current_floor +/-1, counter reloads, evaluate stop at new floor f.
  - Moving up: stop if in[f] | up[f] | !above(f). Serve mask = in[f], up[f], plus down[f] only if !above(f).
  - Moving down: mirror (down[f], !below(f), up[f] only if !below(f)).
  - Stop with empty serve mask -> IDLE (no door). Stop with non-empty mask -> DOOR_OPEN.
  - Floor never leaves 0..BUTTONS_WIDTH-1; end floors always stop because above/below is empty.
- DOOR_OPEN: door_open=1, motors 0. Serve mask latched on entry. clr_* = latched mask for the whole state (level, not one-shot), so re-presses at this floor in the served direction stay cleared. Timer DOOR_TICKS cycles, then DOOR_CLOSING.
- DOOR_CLOSING: door_open=0, clr_* 0. Timer CLOSE_TICKS cycles, then IDLE.
- Requests arriving during MOVING are evaluated at the next floor boundary only. A request appearing at the current floor during DOOR_CLOSING is served via IDLE -> DOOR_OPEN.
- motor_up and motor_down are never both 1. door_open is never 1 while a motor is 1.

Optional Feature:
DOOR_REOPEN_EN. When defined, adds input port door_obstruct (1 bit, after reset in the port list). door_obstruct=1 in DOOR_CLOSING -> next cycle DOOR_OPEN, timer reloads DOOR_TICKS, serve mask kept. door_obstruct=1 in DOOR_OPEN reloads the timer each cycle. When undefined: no such port; DOOR_CLOSING always completes.

Test Plan:
Use FLOOR_TICKS=4, DOOR_TICKS=6, CLOSE_TICKS=3, BUTTONS_WIDTH=8 throughout.
- Reset, then hold in[3]=1 from floor 0 -> 1 IDLE cycle, motor_up for 12 cycles; current_floor steps 1,2,3 every 4 cycles; door_open=1 for 6 cycles with clr_in_levels=8'h08; then 3 closing cycles; then IDLE.
- Car at 0, up[2]=1 and down[5]=1 -> passes floor 2 without stopping? No: stops at 2 (up matches) with clr_out_up=8'h04; continues to 5; at 5 clears down (no requests above).
- Car moving up past floor 2 toward 6, down[4]=1 asserted -> no stop at 4; at 6 reverses; stops at 4 on the way down with clr_out_down=8'h10.
- Requests both above and below in IDLE with dir_up=0 -> travels down first.
- Assert reset low mid-MOVING at floor 4 -> all outputs 0 and current_floor=0 asynchronously, before the next clock edge.
- DOOR_REOPEN_EN defined: pulse door_obstruct during DOOR_CLOSING -> door_open=1 next cycle for 6 more cycles, clr_* mask reasserted.
